// File: rtl/spi_ram_pkg.sv
// Shared opcode, state and command-word definitions for the SPI RAM controller.
package spi_ram_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned DATA_W = 8;

  localparam logic [OP_W-1:0] OP_WR_ADDR = 2'b00;
  localparam logic [OP_W-1:0] OP_WR_DATA = 2'b01;
  localparam logic [OP_W-1:0] OP_RD_ADDR = 2'b10;
  localparam logic [OP_W-1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPI_WR  = 3'd1,
    ST_SPI_RD  = 3'd2,
    ST_SPI_RDW = 3'd3,
    ST_DBG_WR  = 3'd4,
    ST_DBG_RD  = 3'd5,
    ST_DBG_RDW = 3'd6
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI command words into RAM accesses and arbitrates the RAM port
// between the SPI command path (priority) and a debug/scrub requester.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_W-1:0]     rx_data,
  input  logic                 rx_valid,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 ram_we,
  output logic                 ram_re,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [ADDR_SIZE-1:0] dbg_addr,
  input  logic [DATA_W-1:0]    dbg_wdata,
  output logic                 dbg_gnt,
  output logic [DATA_W-1:0]    dbg_rdata,
  output logic                 dbg_rvalid,
  output logic                 cmd_ovf
);

  state_t               state, state_d;
  cmd_t                 pend;
  logic                 pend_valid;
  logic                 consume, accept, drop;
  logic [ADDR_SIZE-1:0] wr_addr, wr_addr_d, rd_addr, rd_addr_d;

  logic                 ram_we_d, ram_re_d, dbg_gnt_d, tx_valid_d, dbg_rvalid_d;
  logic [ADDR_SIZE-1:0] ram_addr_d;
  logic [DATA_W-1:0]    ram_wdata_d, tx_data_d, dbg_rdata_d;

  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
  endfunction

  // Pending entry is freed in the cycle IDLE consumes it, so a word arriving then is kept.
  assign accept = rx_valid && (!pend_valid || consume);
  assign drop   = rx_valid && pend_valid && !consume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pend       <= '0;
      pend_valid <= 1'b0;
      cmd_ovf    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      dbg_gnt    <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      state      <= state_d;
      if (accept) begin
        pend       <= cmd_t'(rx_data);
        pend_valid <= 1'b1;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
      cmd_ovf    <= cmd_ovf | drop;
      wr_addr    <= wr_addr_d;
      rd_addr    <= rd_addr_d;
      ram_we     <= ram_we_d;
      ram_re     <= ram_re_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      dbg_gnt    <= dbg_gnt_d;
      dbg_rvalid <= dbg_rvalid_d;
      dbg_rdata  <= dbg_rdata_d;
    end
  end

  // Next state plus next values of the registered outputs: strobes are set on
  // entry to an access state so they line up with that state's cycle.
  always_comb begin
    state_d      = state;
    consume      = 1'b0;
    wr_addr_d    = wr_addr;
    rd_addr_d    = rd_addr;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    tx_valid_d   = 1'b0;
    tx_data_d    = tx_data;
    dbg_gnt_d    = 1'b0;
    dbg_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata;

    unique case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          consume = 1'b1;
          case (pend.op)
            OP_WR_ADDR: wr_addr_d = ADDR_SIZE'(pend.payload);
            OP_RD_ADDR: rd_addr_d = ADDR_SIZE'(pend.payload);
            OP_WR_DATA: begin
              state_d     = ST_SPI_WR;
              ram_we_d    = 1'b1;
              ram_addr_d  = wr_addr;
              ram_wdata_d = pend.payload;
            end
            OP_RD_DATA: begin
              state_d    = ST_SPI_RD;
              ram_re_d   = 1'b1;
              ram_addr_d = rd_addr;
            end
          endcase
        end else if (dbg_req && !rx_valid) begin
          // A word arriving this cycle still outranks debug.
          dbg_gnt_d  = 1'b1;
          ram_addr_d = dbg_addr;
          if (dbg_we) begin
            state_d     = ST_DBG_WR;
            ram_we_d    = 1'b1;
            ram_wdata_d = dbg_wdata;
          end else begin
            state_d  = ST_DBG_RD;
            ram_re_d = 1'b1;
          end
        end
      end
      ST_SPI_WR: begin
        wr_addr_d = next_ptr(wr_addr);
        state_d   = ST_IDLE;
      end
      ST_SPI_RD: begin
        rd_addr_d = next_ptr(rd_addr);
        state_d   = ST_SPI_RDW;
      end
      ST_SPI_RDW: begin
        tx_valid_d = 1'b1;
        tx_data_d  = ram_rdata;
        state_d    = ST_IDLE;
      end
      ST_DBG_WR: state_d = ST_IDLE;
      ST_DBG_RD: state_d = ST_DBG_RDW;
      ST_DBG_RDW: begin
        dbg_rvalid_d = 1'b1;
        dbg_rdata_d  = ram_rdata;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: vector table plus scoreboarded RAM/tx/debug events.
module tb_spi_ram_ctrl;
  import spi_ram_pkg::*;

  localparam int unsigned ADDR_SIZE = 8;
  localparam int unsigned MEM_DEPTH = 256;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [9:0]           rx_data;
  logic                 rx_valid;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 ram_we, ram_re;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;
  logic                 dbg_req, dbg_we;
  logic [ADDR_SIZE-1:0] dbg_addr;
  logic [7:0]           dbg_wdata;
  logic                 dbg_gnt;
  logic [7:0]           dbg_rdata;
  logic                 dbg_rvalid;
  logic                 cmd_ovf;

  spi_ram_ctrl #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .cmd_ovf(cmd_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] pl;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;

  exp_t wq[$], rq[$], tq[$], dq[$];
  int   checks = 0, errors = 0, cyc = 0, gnt_cnt = 0, gnt_cyc = -1;
  logic [7:0] mem [MEM_DEPTH];
  vec_t vecs[13];

  always @(posedge clk) cyc++;

  // Single-port synchronous RAM model: read data valid the cycle after ram_re.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected strobe at cycle %0d", name, cyc);
  endtask

  function automatic logic [47:0] all_outs();
    return 48'({tx_data, tx_valid, ram_we, ram_re, ram_addr, ram_wdata,
                dbg_gnt, dbg_rdata, dbg_rvalid, cmd_ovf});
  endfunction

  // Output monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (ram_we) begin
      if (wq.size() == 0) unexpected("ram_we");
      else begin e = wq.pop_front(); cmp("ram_write", {32'(cyc), ram_addr, ram_wdata}, {32'(e.cyc), e.addr, e.data}); end
    end
    if (ram_re) begin
      if (rq.size() == 0) unexpected("ram_re");
      else begin e = rq.pop_front(); cmp("ram_read", {32'(cyc), ram_addr, 8'h00}, {32'(e.cyc), e.addr, 8'h00}); end
    end
    if (tx_valid) begin
      if (tq.size() == 0) unexpected("tx_valid");
      else begin e = tq.pop_front(); cmp("tx", {32'(cyc), 8'h00, tx_data}, {32'(e.cyc), 8'h00, e.data}); end
    end
    if (dbg_rvalid) begin
      if (dq.size() == 0) unexpected("dbg_rvalid");
      else begin e = dq.pop_front(); cmp("dbg_read", {32'(cyc), 8'h00, dbg_rdata}, {32'(e.cyc), 8'h00, e.data}); end
    end
    if (dbg_gnt) begin
      gnt_cnt++;
      gnt_cyc = cyc;
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] pl, output int c0);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = {op, pl};
    c0       = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic push_vec(input vec_t v, input int c0);
    if (v.op == OP_WR_DATA) wq.push_back('{addr: v.exp_addr, data: v.exp_data, cyc: c0 + 2});
    if (v.op == OP_RD_DATA) begin
      rq.push_back('{addr: v.exp_addr, data: 8'h00, cyc: c0 + 2});
      tq.push_back('{addr: 8'h00, data: v.exp_data, cyc: c0 + 4});
    end
  endtask

  task automatic wait_gnt(input int g0);
    for (int i = 0; i < 20 && gnt_cnt == g0; i++) @(posedge clk);
    #1 dbg_req = 1'b0;
  endtask

  initial begin
    int   c0, g0;
    vec_t v;

    vecs[0]  = '{OP_WR_ADDR, 8'h10, 8'h00, 8'h00};
    vecs[1]  = '{OP_WR_DATA, 8'hA5, 8'h10, 8'hA5};
    vecs[2]  = '{OP_WR_DATA, 8'h5A, 8'h11, 8'h5A};
    vecs[3]  = '{OP_WR_DATA, 8'h77, 8'h12, 8'h77};
    vecs[4]  = '{OP_RD_ADDR, 8'h10, 8'h00, 8'h00};
    vecs[5]  = '{OP_RD_DATA, 8'h00, 8'h10, 8'hA5};
    vecs[6]  = '{OP_RD_DATA, 8'hEE, 8'h11, 8'h5A};
    vecs[7]  = '{OP_WR_ADDR, 8'hFF, 8'h00, 8'h00};
    vecs[8]  = '{OP_WR_DATA, 8'h11, 8'hFF, 8'h11};
    vecs[9]  = '{OP_WR_DATA, 8'h22, 8'h00, 8'h22};
    vecs[10] = '{OP_RD_ADDR, 8'hFF, 8'h00, 8'h00};
    vecs[11] = '{OP_RD_DATA, 8'h00, 8'hFF, 8'h11};
    vecs[12] = '{OP_RD_DATA, 8'h00, 8'h00, 8'h22};

    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 8'h00;
    ram_rdata = 8'h00;
    rst = 1'b0; rx_valid = 1'b0; rx_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    repeat (3) @(posedge clk);
    #1 cmp("reset_outputs", all_outs(), 48'h0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);

    // Table: address loads, writes, reads, wrap-around.
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      send(v.op, v.pl, c0);
      push_vec(v, c0);
      repeat (4) @(posedge clk);
    end

    // Debug read arriving with an SPI write: SPI goes first (wr_addr is 0x01 here).
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = {OP_WR_DATA, 8'h3C};
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10;
    c0 = cyc; g0 = gnt_cnt;
    wq.push_back('{addr: 8'h01, data: 8'h3C, cyc: c0 + 2});
    rq.push_back('{addr: 8'h10, data: 8'h00, cyc: c0 + 4});
    dq.push_back('{addr: 8'h00, data: 8'hA5, cyc: c0 + 6});
    @(posedge clk); #1 rx_valid = 1'b0;
    wait_gnt(g0);
    cmp("dbg_rd_gnt_cycle", 48'(gnt_cyc), 48'(c0 + 4));
    repeat (4) @(posedge clk);

    // Debug write, then SPI reads it back; pointers untouched by debug.
    @(posedge clk); #1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'hC3;
    c0 = cyc; g0 = gnt_cnt;
    wq.push_back('{addr: 8'h30, data: 8'hC3, cyc: c0 + 1});
    wait_gnt(g0);
    cmp("dbg_wr_gnt_cycle", 48'(gnt_cyc), 48'(c0 + 1));
    repeat (3) @(posedge clk);
    send(OP_RD_ADDR, 8'h30, c0); repeat (4) @(posedge clk);
    send(OP_RD_DATA, 8'h00, c0); push_vec('{OP_RD_DATA, 8'h00, 8'h30, 8'hC3}, c0);
    repeat (4) @(posedge clk);
    send(OP_WR_DATA, 8'h4D, c0); push_vec('{OP_WR_DATA, 8'h4D, 8'h02, 8'h4D}, c0);
    repeat (4) @(posedge clk);

    // Overflow: two words back to back while a read is in flight.
    send(OP_RD_ADDR, 8'h10, c0); repeat (4) @(posedge clk);
    send(OP_RD_DATA, 8'h00, c0); push_vec('{OP_RD_DATA, 8'h00, 8'h10, 8'hA5}, c0);
    cmp("cmd_ovf_before", 48'(cmd_ovf), 48'h0);
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = {OP_WR_ADDR, 8'h40};
    @(posedge clk); #1; rx_data = {OP_WR_DATA, 8'h99};
    @(posedge clk); #1; rx_valid = 1'b0;
    @(negedge clk) cmp("cmd_ovf_set", 48'(cmd_ovf), 48'h1);
    repeat (3) @(posedge clk);
    send(OP_WR_DATA, 8'h5E, c0); push_vec('{OP_WR_DATA, 8'h5E, 8'h40, 8'h5E}, c0);
    repeat (6) @(posedge clk);
    @(negedge clk) cmp("cmd_ovf_sticky", 48'(cmd_ovf), 48'h1);

    // Reset while in SPI_RDW: read data must never come out.
    send(OP_RD_ADDR, 8'h11, c0); repeat (4) @(posedge clk);
    send(OP_RD_DATA, 8'h00, c0);
    rq.push_back('{addr: 8'h11, data: 8'h00, cyc: c0 + 2});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 cmp("reset_in_rdw", all_outs(), 48'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    send(OP_WR_DATA, 8'h66, c0); push_vec('{OP_WR_DATA, 8'h66, 8'h00, 8'h66}, c0);
    repeat (4) @(posedge clk);
    send(OP_RD_DATA, 8'h00, c0); push_vec('{OP_RD_DATA, 8'h00, 8'h00, 8'h66}, c0);
    repeat (4) @(posedge clk);

    for (int i = 0; i < 50 && (wq.size() + rq.size() + tq.size() + dq.size()) != 0; i++)
      @(posedge clk);
    cmp("queues_drained", 48'(wq.size() + rq.size() + tq.size() + dq.size()), 48'h0);
    cmp("dbg_gnt_count", 48'(gnt_cnt), 48'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Sits between the SPI slave frame decoder and the single-port RAM.
- Decodes 10-bit SPI command words into address loads, RAM writes and RAM reads, and returns read bytes as tx_data/tx_valid.
- Arbitrates the single RAM port between the SPI command path (priority) and a debug/scrub requester.
- Owns the write/read address pointers and all RAM strobes.

Parameters:
- MEM_DEPTH, 256: number of RAM words.
- ADDR_SIZE, 8: RAM address width. Requires MEM_DEPTH <= 2**ADDR_SIZE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  10  SPI command word: [9:8] opcode, [7:0] payload.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- tx_data  out  8  read byte returned to the SPI slave.
- tx_valid  out  1  one-cycle strobe qualifying tx_data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_SIZE  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after ram_re.
- dbg_req  in  1  debug request, level; held until dbg_gnt.
- dbg_we  in  1  debug access type: 1 = write, 0 = read.
- dbg_addr  in  ADDR_SIZE  debug address.
- dbg_wdata  in  8  debug write data.
- dbg_gnt  out  1  one-cycle pulse; the debug access is issued this cycle.
- dbg_rdata  out  8  debug read data.
- dbg_rvalid  out  1  one-cycle strobe qualifying dbg_rdata.
- cmd_ovf  out  1  sticky flag: an SPI command was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - wr_addr = rd_addr = 0.
  - Pending buffer empty; FSM to IDLE.
  - Any in-flight read is discarded: no tx_valid or dbg_rvalid after reset release.
- Pending buffer:
  - Single entry; captures rx_data on rx_valid.
  - rx_valid while the entry is full and not being consumed in that cycle: word is dropped and cmd_ovf set. cmd_ovf clears only on reset.
  - rx_valid in the same cycle the entry is consumed: the new word is accepted.
- Opcodes:
  - 00 WR_ADDR: wr_addr <= payload. No RAM access.
  - 01 WR_DATA: mem[wr_addr] <= payload, then wr_addr increments.
  - 10 RD_ADDR: rd_addr <= payload. No RAM access.
  - 11 RD_DATA: read mem[rd_addr], return the byte on tx_data, then rd_addr increments. Payload is ignored.
- Pointer wrap: each pointer increments modulo MEM_DEPTH (MEM_DEPTH-1 -> 0).
- FSM states: IDLE, SPI_WR, SPI_RD, SPI_RDW, DBG_WR, DBG_RD, DBG_RDW.
- IDLE:
  - Pending entry present: 00/10 execute in this cycle (pending is consumed, FSM stays in IDLE); 01 -> SPI_WR; 11 -> SPI_RD.
  - Else if dbg_req: dbg_gnt=1 this cycle, latch the debug request, go to DBG_WR or DBG_RD.
  - SPI always has priority over debug; debug is granted only when pending is empty.
- SPI_WR: ram_we=1, ram_addr=wr_addr, ram_wdata=payload for one cycle; wr_addr increments; -> IDLE.
- SPI_RD: ram_re=1, ram_addr=rd_addr for one cycle; rd_addr increments; -> SPI_RDW.
- SPI_RDW: register ram_rdata into tx_data; tx_valid=1 in the next cycle; -> IDLE.
- DBG_WR, DBG_RD, DBG_RDW: as the SPI states, using the latched dbg_addr/dbg_wdata. dbg_rvalid/dbg_rdata replace tx_valid/tx_data. Debug accesses never change the pointers.
- Latency, with rx_valid in cycle 0 and FSM idle:
  - Write: ram_we in cycle 2.
  - Read: ram_re in cycle 2, tx_valid in cycle 4.
  - Address loads take effect at the end of cycle 1.
- Outputs are registered. ram_* signals are 0 outside access states.
- Strobes tx_valid, dbg_gnt and dbg_rvalid are exactly one cycle wide.

Decomposition:
- Package spi_ram_pkg:
  - Opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - FSM state encoding, 3 bits.
- Implemented flat, with no sub-module; the pending buffer is a few registers inside the block.

Test Plan:
- WR_ADDR 0x10, then WR_DATA 0xA5, 0x5A -> ram_we at addresses 0x10 and 0x11 with data 0xA5 and 0x5A; wr_addr ends at 0x12.
- RD_ADDR 0x10, then RD_DATA twice -> tx_valid pulses with 0xA5 then 0x5A, each exactly 4 cycles after its rx_valid.
- WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> writes land at 0xFF and 0x00 (wrap-around).
- dbg_req read of 0x10 held while an SPI WR_DATA arrives in the same cycle -> SPI write is issued first; dbg_gnt follows; dbg_rvalid returns 0xA5; tx_valid never fires for the debug read.
- Two rx_valid one cycle apart while a read is in flight -> second word dropped; cmd_ovf=1 and stays 1 until reset.
- rst asserted in SPI_RDW -> all outputs 0 immediately; no tx_valid after release; pointers read back 0.
